// File: rtl/sram_req_arbiter_if.sv
// sram_req_arbiter_if: SRAM-like request/response bundle; master issues requests, slave accepts and responds
interface sram_req_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    modport master(output req, wr, size, wstrb, addr, wdata, input addr_ok, data_ok, rdata);
    modport slave(input req, wr, size, wstrb, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: shares one SRAM-like port between fetch and load/store, routing in-order responses by owner
module sram_req_arbiter #(
    parameter int DEPTH = 4
) (
    input logic               clk,
    input logic               reset,
    input logic               inst_cancel,
    sram_req_arbiter_if.slave  inst,
    sram_req_arbiter_if.slave  data,
    sram_req_arbiter_if.master mem
);
    localparam int AW = $clog2(DEPTH);
    logic [AW-1:0]  wp, rp;
    logic [AW:0]    count;
    logic [DEPTH-1:0] id_q, drop_q;
    logic full, nonempty, sel_data, push, pop;
    assign full     = count == (AW+1)'(DEPTH);
    assign nonempty = count != '0;
    assign sel_data = data.req;
    assign mem.req   = ~full & (data.req | inst.req);
    assign mem.wr    = sel_data ? data.wr    : inst.wr;
    assign mem.size  = sel_data ? data.size  : inst.size;
    assign mem.wstrb = sel_data ? data.wstrb : inst.wstrb;
    assign mem.addr  = sel_data ? data.addr  : inst.addr;
    assign mem.wdata = sel_data ? data.wdata : inst.wdata;
    assign push = mem.req & mem.addr_ok;
    assign pop  = mem.data_ok & nonempty;
    assign data.addr_ok = push & sel_data;
    assign inst.addr_ok = push & ~sel_data;
    assign data.data_ok = pop & id_q[rp];
    assign inst.data_ok = pop & ~id_q[rp] & ~drop_q[rp] & ~inst_cancel;
    assign data.rdata = mem.rdata;
    assign inst.rdata = mem.rdata;
    // cancel marks every fetch slot; stale slots are rewritten on push, so only live entries matter
    always_ff @(posedge clk) begin
        if (reset) begin
            wp     <= '0;
            rp     <= '0;
            count  <= '0;
            id_q   <= '0;
            drop_q <= '0;
        end else begin
            if (inst_cancel) drop_q <= drop_q | ~id_q;
            if (push) begin
                id_q[wp]   <= sel_data;
                drop_q[wp] <= ~sel_data & inst_cancel;
                wp         <= wp + AW'(1);
            end
            if (pop) rp <= rp + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb_sram_req_arbiter: directed vectors for grant priority, in-order routing, full stall and fetch cancel
module tb_sram_req_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic inst_cancel = 1'b0;
    int n_checks = 0;
    int n_errors = 0;
    sram_req_arbiter_if inst_bus();
    sram_req_arbiter_if data_bus();
    sram_req_arbiter_if mem_bus();
    sram_req_arbiter #(.DEPTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .inst_cancel(inst_cancel),
        .inst(inst_bus),
        .data(data_bus),
        .mem(mem_bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic drive_inst(input logic req, input logic [31:0] addr);
        inst_bus.req   = req;
        inst_bus.wr    = 1'b0;
        inst_bus.size  = 2'd2;
        inst_bus.wstrb = 4'h0;
        inst_bus.addr  = addr;
        inst_bus.wdata = 32'h0;
    endtask
    task automatic drive_data(input logic req, input logic wr, input logic [31:0] addr, input logic [3:0] wstrb);
        data_bus.req   = req;
        data_bus.wr    = wr;
        data_bus.size  = 2'd2;
        data_bus.wstrb = wstrb;
        data_bus.addr  = addr;
        data_bus.wdata = 32'hDEADBEEF;
    endtask
    task automatic drive_mem(input logic aok, input logic dok, input logic [31:0] rdata);
        mem_bus.addr_ok = aok;
        mem_bus.data_ok = dok;
        mem_bus.rdata   = rdata;
    endtask
    task automatic idle();
        drive_inst(1'b0, 32'h0);
        drive_data(1'b0, 1'b0, 32'h0, 4'h0);
        drive_mem(1'b1, 1'b0, 32'h0);
        inst_cancel = 1'b0;
    endtask
    initial begin
        idle();
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst mem_req", 32'(mem_bus.req), 32'd0);
        check("rst inst_addr_ok", 32'(inst_bus.addr_ok), 32'd0);
        check("rst data_data_ok", 32'(data_bus.data_ok), 32'd0);
        check("rst count", 32'(dut.count), 32'd0);
        // empty-FIFO response is ignored
        tick(); drive_mem(1'b1, 1'b1, 32'h77); #1;
        check("empty inst_data_ok", 32'(inst_bus.data_ok), 32'd0);
        check("empty data_data_ok", 32'(data_bus.data_ok), 32'd0);
        tick(); idle(); #1;
        check("empty count", 32'(dut.count), 32'd0);
        // single fetch
        tick(); drive_inst(1'b1, 32'h1C000000); #1;
        check("fetch mem_req", 32'(mem_bus.req), 32'd1);
        check("fetch mem_addr", mem_bus.addr, 32'h1C000000);
        check("fetch inst_addr_ok", 32'(inst_bus.addr_ok), 32'd1);
        tick(); idle(); #1;
        check("fetch count1", 32'(dut.count), 32'd1);
        tick(); drive_mem(1'b1, 1'b1, 32'h02800404); #1;
        check("fetch inst_data_ok", 32'(inst_bus.data_ok), 32'd1);
        check("fetch inst_rdata", inst_bus.rdata, 32'h02800404);
        check("fetch data_data_ok", 32'(data_bus.data_ok), 32'd0);
        tick(); idle(); #1;
        check("fetch count0", 32'(dut.count), 32'd0);
        // priority
        tick(); drive_inst(1'b1, 32'h1C000100); drive_data(1'b1, 1'b1, 32'h1C008000, 4'hF); #1;
        check("prio mem_addr", mem_bus.addr, 32'h1C008000);
        check("prio mem_wr", 32'(mem_bus.wr), 32'd1);
        check("prio mem_wstrb", 32'(mem_bus.wstrb), 32'hF);
        check("prio data_addr_ok", 32'(data_bus.addr_ok), 32'd1);
        check("prio inst_addr_ok", 32'(inst_bus.addr_ok), 32'd0);
        tick(); drive_data(1'b0, 1'b0, 32'h0, 4'h0); #1;
        check("prio inst later", 32'(inst_bus.addr_ok), 32'd1);
        check("prio mem_addr2", mem_bus.addr, 32'h1C000100);
        tick(); idle(); #1;
        check("prio count", 32'(dut.count), 32'd2);
        tick(); drive_mem(1'b1, 1'b1, 32'h11); #1;
        check("prio resp data", 32'(data_bus.data_ok), 32'd1);
        check("prio resp no inst", 32'(inst_bus.data_ok), 32'd0);
        tick(); drive_mem(1'b1, 1'b1, 32'h22); #1;
        check("prio resp inst", 32'(inst_bus.data_ok), 32'd1);
        check("prio resp no data", 32'(data_bus.data_ok), 32'd0);
        // ordering
        tick(); idle(); drive_inst(1'b1, 32'h100); #1;
        check("ord acc0", 32'(inst_bus.addr_ok), 32'd1);
        tick(); drive_inst(1'b0, 32'h0); drive_data(1'b1, 1'b0, 32'h200, 4'h0); #1;
        check("ord acc1", 32'(data_bus.addr_ok), 32'd1);
        tick(); drive_data(1'b0, 1'b0, 32'h0, 4'h0); drive_inst(1'b1, 32'h104); #1;
        check("ord acc2", 32'(inst_bus.addr_ok), 32'd1);
        tick(); idle(); drive_mem(1'b1, 1'b1, 32'hA); #1;
        check("ord r0 inst", 32'(inst_bus.data_ok), 32'd1);
        check("ord r0 rdata", inst_bus.rdata, 32'hA);
        tick(); drive_mem(1'b1, 1'b1, 32'hB); #1;
        check("ord r1 data", 32'(data_bus.data_ok), 32'd1);
        check("ord r1 no inst", 32'(inst_bus.data_ok), 32'd0);
        check("ord r1 rdata", data_bus.rdata, 32'hB);
        tick(); drive_mem(1'b1, 1'b1, 32'hC); #1;
        check("ord r2 inst", 32'(inst_bus.data_ok), 32'd1);
        check("ord r2 rdata", inst_bus.rdata, 32'hC);
        // full
        tick(); idle();
        for (int i = 0; i < 4; i++) begin
            drive_inst(1'b1, 32'h300 + 32'(i * 4)); #1;
            check($sformatf("full acc%0d", i), 32'(inst_bus.addr_ok), 32'd1);
            tick();
        end
        #1;
        check("full mem_req", 32'(mem_bus.req), 32'd0);
        check("full no accept", 32'(inst_bus.addr_ok), 32'd0);
        check("full count", 32'(dut.count), 32'd4);
        tick(); drive_mem(1'b1, 1'b1, 32'h55); #1;
        check("full pop mem_req", 32'(mem_bus.req), 32'd0);
        check("full pop resp", 32'(inst_bus.data_ok), 32'd1);
        tick(); drive_mem(1'b1, 1'b0, 32'h0); #1;
        check("full reaccept", 32'(inst_bus.addr_ok), 32'd1);
        tick(); drive_inst(1'b0, 32'h0); drive_mem(1'b1, 1'b1, 32'h66);
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("full drain%0d", i), 32'(inst_bus.data_ok), 32'd1);
            tick();
        end
        idle(); #1;
        check("full count0", 32'(dut.count), 32'd0);
        // cancel with two fetches and one data outstanding
        drive_inst(1'b1, 32'h400); tick(); tick();
        drive_inst(1'b0, 32'h0); drive_data(1'b1, 1'b0, 32'h500, 4'h0); tick();
        idle(); inst_cancel = 1'b1; #1;
        check("cxl count", 32'(dut.count), 32'd3);
        tick(); inst_cancel = 1'b0; drive_mem(1'b1, 1'b1, 32'h81); #1;
        check("cxl r0 inst", 32'(inst_bus.data_ok), 32'd0);
        check("cxl r0 data", 32'(data_bus.data_ok), 32'd0);
        tick(); #1;
        check("cxl r1 inst", 32'(inst_bus.data_ok), 32'd0);
        check("cxl r1 data", 32'(data_bus.data_ok), 32'd0);
        tick(); #1;
        check("cxl r2 inst", 32'(inst_bus.data_ok), 32'd0);
        check("cxl r2 data", 32'(data_bus.data_ok), 32'd1);
        tick(); idle(); drive_inst(1'b1, 32'h600); #1;
        check("cxl count0", 32'(dut.count), 32'd0);
        tick(); drive_inst(1'b0, 32'h0); drive_mem(1'b1, 1'b1, 32'h99); #1;
        check("cxl new fetch", 32'(inst_bus.data_ok), 32'd1);
        // cancel colliding with an inst accept and an inst pop
        tick(); idle(); drive_inst(1'b1, 32'h700); tick();
        drive_inst(1'b1, 32'h704); drive_mem(1'b1, 1'b1, 32'hAA); inst_cancel = 1'b1; #1;
        check("sim accept", 32'(inst_bus.addr_ok), 32'd1);
        check("sim pop suppressed", 32'(inst_bus.data_ok), 32'd0);
        tick(); idle(); #1;
        check("sim count", 32'(dut.count), 32'd1);
        tick(); drive_mem(1'b1, 1'b1, 32'hBB); #1;
        check("sim dropped", 32'(inst_bus.data_ok), 32'd0);
        tick(); idle(); #1;
        check("sim count0", 32'(dut.count), 32'd0);
        // reset mid-operation discards outstanding entries
        drive_inst(1'b1, 32'h800); tick(); tick();
        idle(); reset = 1'b1; tick(); reset = 1'b0; #1;
        check("mid rst count", 32'(dut.count), 32'd0);
        drive_mem(1'b1, 1'b1, 32'hCC); #1;
        check("mid rst no resp", 32'(inst_bus.data_ok), 32'd0);
        tick(); idle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
